imem_load_ctrl: RTL and testbench

- Sequences the instruction memory between two users: a program-load stream that writes program words, and the CPU fetch port that reads by PC.
- Holds the CPU stalled from reset until a complete program has been written.
- Re-stalls the CPU for any later reload.
- Sits between the fetch stage and a writable single-port instruction RAM that replaces the fixed ROM for reloadable builds.

---
 rtl/imem_load_ctrl_pkg.sv | 19 +
 rtl/imem_ram.sv | 29 ++
 rtl/imem_load_ctrl.sv | 151 +++++++++++++++
 tb/tb_imem_load_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the reloadable instruction-memory path:
// controller state encodings, default widths and the NOP word.
package imem_load_ctrl_pkg;

   localparam int INSTR_MEM_ADDR_WIDTH = 8;
   localparam int PC_WIDTH             = 8;
   localparam int INSTR_WORD_WIDTH     = 16;

   // All-zero word is the CPU NOP; it is fed to the pipeline while stalled.
   localparam logic [15:0] INSTR_NOP = 16'h0000;

   typedef enum logic [1:0] {
      IMEM_ST_BOOT   = 2'd0,
      IMEM_ST_LOAD   = 2'd1,
      IMEM_ST_FINISH = 2'd2,
      IMEM_ST_RUN    = 2'd3
   } imem_state_e;

endpackage

// File: rtl/imem_ram.sv
// Single-port instruction RAM: synchronous write, asynchronous read.
// Contents are not reset, so a partially loaded program survives a reset.
module imem_ram
   import imem_load_ctrl_pkg::*;
#(
   parameter int ADDR_W = INSTR_MEM_ADDR_WIDTH,
   parameter int WORD_W = INSTR_WORD_WIDTH
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0] mem [DEPTH];

   // Write port: one word per cycle when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load sequencer. Arbitrates the single RAM port between
// the program-load stream and CPU fetch, holding the CPU stalled until a
// complete program has been written.
//
//  state          | meaning
//  ---------------+---------------------------------------------------
//  IMEM_ST_BOOT   | after reset, no valid program yet, CPU stalled
//  IMEM_ST_LOAD   | accepting program words, CPU stalled
//  IMEM_ST_FINISH | one cycle after the last word; done pulses
//  IMEM_ST_RUN    | program valid, CPU fetches by PC
module imem_load_ctrl
   import imem_load_ctrl_pkg::*;
#(
   parameter int ADDR_W = INSTR_MEM_ADDR_WIDTH,
   parameter int PC_W   = PC_WIDTH,
   parameter int WORD_W = INSTR_WORD_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              load_valid,
   input  logic [WORD_W-1:0] load_data,
   output logic              load_ready,
   input  logic [PC_W-1:0]   pc,
   output logic [WORD_W-1:0] instruction,
   output logic              cpu_stall,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              checksum_unused_dummy_never,
   output logic [WORD_W-1:0] checksum
);

   // Largest legal length is the full RAM depth, which needs the extra bit.
   localparam logic [ADDR_W:0]   DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   ONE_LEN   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

   imem_state_e       state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic [WORD_W-1:0] checksum_q, checksum_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              len_legal;
   logic              idle;

   // Only the low ADDR_W bits of the PC address the RAM.
   if (PC_W > ADDR_W) begin : g_pc_hi
      logic pc_hi_unused;
      assign pc_hi_unused = ^pc[PC_W-1:ADDR_W];
   end

   assign checksum_unused_dummy_never = 1'b0;

   // Start legality: non-empty and no longer than the RAM.
   always_comb begin
      len_legal = (load_len != '0) && (load_len <= DEPTH_LEN);
      idle      = (state_q == IMEM_ST_BOOT) || (state_q == IMEM_ST_RUN);
   end

   // State and datapath registers; RAM contents are deliberately not reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IMEM_ST_BOOT;
         wr_addr_q   <= '0;
         remaining_q <= '0;
         checksum_q  <= '0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_addr_q   <= wr_addr_d;
         remaining_q <= remaining_d;
         checksum_q  <= checksum_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   // Next-state logic and write-port control.
   always_comb begin
      state_d     = state_q;
      wr_addr_d   = wr_addr_q;
      remaining_d = remaining_q;
      checksum_d  = checksum_q;
      busy_d      = busy_q;
      err_d       = 1'b0;
      load_ready  = 1'b0;
      mem_we      = 1'b0;
      done        = 1'b0;

      case (state_q)
         IMEM_ST_BOOT,
         IMEM_ST_RUN: begin
            if (load_start) begin
               if (len_legal) begin
                  state_d     = IMEM_ST_LOAD;
                  remaining_d = load_len;
                  wr_addr_d   = '0;
                  checksum_d  = '0;
                  busy_d      = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         IMEM_ST_LOAD: begin
            load_ready = 1'b1;
            if (load_valid) begin
               mem_we      = 1'b1;
               wr_addr_d   = wr_addr_q + ONE_ADDR;
               remaining_d = remaining_q - ONE_LEN;
               checksum_d  = checksum_q ^ load_data;
               if (remaining_q == ONE_LEN) begin
                  state_d = IMEM_ST_FINISH;
               end
            end
         end

         IMEM_ST_FINISH: begin
            done    = 1'b1;
            busy_d  = 1'b0;
            state_d = IMEM_ST_RUN;
         end

         default: begin
            state_d = IMEM_ST_BOOT;
         end
      endcase
   end

   // Fetch side: the CPU only ever sees RAM data once a program is complete.
   always_comb begin
      mem_addr    = (state_q == IMEM_ST_LOAD) ? wr_addr_q : pc[ADDR_W-1:0];
      mem_wdata   = load_data;
      cpu_stall   = (state_q != IMEM_ST_RUN);
      instruction = (state_q == IMEM_ST_RUN) ? mem_rdata : WORD_W'(INSTR_NOP);
   end

   assign busy     = busy_q;
   assign err      = err_q;
   assign checksum = checksum_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl with a real imem_ram beside it.
module tb_imem_load_ctrl;
   import imem_load_ctrl_pkg::*;

   localparam int ADDR_W = 8;
   localparam int PC_W   = 8;
   localparam int WORD_W = 16;

   typedef struct packed {
      logic [7:0]  addr;
      logic [15:0] data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              load_start = 1'b0;
   logic [ADDR_W:0]   load_len = '0;
   logic              load_valid = 1'b0;
   logic [WORD_W-1:0] load_data = '0;
   logic              load_ready;
   logic [PC_W-1:0]   pc = '0;
   logic [WORD_W-1:0] instruction;
   logic              cpu_stall;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic [WORD_W-1:0] mem_rdata;
   logic              busy;
   logic              done;
   logic              err;
   logic              dummy_out;
   logic [WORD_W-1:0] checksum;

   always #5 clk = ~clk;

   imem_load_ctrl #(.ADDR_W(ADDR_W), .PC_W(PC_W), .WORD_W(WORD_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .load_len(load_len),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .pc(pc), .instruction(instruction), .cpu_stall(cpu_stall),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err),
      .checksum_unused_dummy_never(dummy_out), .checksum(checksum)
   );

   imem_ram #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_ram (
      .clk(clk), .we(mem_we), .addr(mem_addr), .wdata(mem_wdata), .rdata(mem_rdata)
   );

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int start_cyc = 0;
   int last_done_cyc = 0;

   wr_t         exp_wr_q [$];
   logic [15:0] exp_done_q [$];
   int          exp_err = 0;
   logic [15:0] wbuf [256];

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: pops expectations whenever the DUT presents a write, done or err.
   logic        after_done = 1'b0;
   wr_t         mon_e;
   logic [15:0] mon_c;
   always @(negedge clk) begin
      if (!rst_n) begin
         after_done = 1'b0;
      end else begin
         if (after_done) begin
            check("stall_after_done", 32'(cpu_stall), 32'd0);
            check("busy_after_done", 32'(busy), 32'd0);
            after_done = 1'b0;
         end
         if (mem_we) begin
            if (exp_wr_q.size() == 0) begin
               check("unexpected_write", 32'(mem_we), 32'd0);
            end else begin
               mon_e = exp_wr_q.pop_front();
               check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
               check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
            end
         end
         if (done) begin
            last_done_cyc = cyc;
            if (exp_done_q.size() == 0) begin
               check("unexpected_done", 32'(done), 32'd0);
            end else begin
               mon_c = exp_done_q.pop_front();
               check("done_checksum", 32'(checksum), 32'(mon_c));
               check("stall_in_finish", 32'(cpu_stall), 32'd1);
               after_done = 1'b1;
            end
         end
         if (err) begin
            if (exp_err == 0) begin
               check("unexpected_err", 32'(err), 32'd0);
            end else begin
               exp_err--;
               check("err_stall", 32'(cpu_stall), 32'd1);
            end
         end
      end
   end

   task automatic expect_load(input int len, input int n_issue);
      logic [15:0] cs;
      wr_t e;
      cs = '0;
      for (int i = 0; i < n_issue; i++) begin
         e.addr = 8'(i);
         e.data = wbuf[i];
         exp_wr_q.push_back(e);
         cs ^= wbuf[i];
      end
      if (n_issue == len) exp_done_q.push_back(cs);
   endtask

   // Called just after a rising edge; holds load_start for one cycle.
   task automatic issue_start(input int len);
      load_start = 1'b1;
      load_len   = 9'(len);
      start_cyc  = cyc;
      @(posedge clk); #1;
      load_start = 1'b0;
      load_len   = '0;
   endtask

   // Streams n words; pat gives load_valid for the first pat_len steps.
   task automatic stream(input int n, input int pat_len, input logic [15:0] pat, input int inj_step);
      int   k;
      int   step;
      logic acc;
      k = 0;
      step = 0;
      while (k < n && step < 1000) begin
         load_valid = (step < pat_len) ? pat[step[3:0]] : 1'b1;
         load_data  = wbuf[k];
         if (step == inj_step) begin
            load_start = 1'b1;
            load_len   = 9'd5;
         end
         @(negedge clk);
         acc = load_valid && load_ready;
         if (step == inj_step) begin
            check("reload_stall", 32'(cpu_stall), 32'd1);
            check("reload_nop", 32'(instruction), 32'd0);
         end
         @(posedge clk); #1;
         load_start = 1'b0;
         load_len   = '0;
         if (acc) k++;
         step++;
      end
      load_valid = 1'b0;
      check("stream_count", 32'(k), 32'(n));
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while ((exp_wr_q.size() != 0 || exp_done_q.size() != 0 || exp_err != 0) && t < 400) begin
         @(posedge clk); #1;
         t++;
      end
      repeat (2) begin @(posedge clk); #1; end
      check("drain", 32'(exp_wr_q.size() + exp_done_q.size() + exp_err), 32'd0);
   endtask

   task automatic fetch(input int a, input logic [15:0] exp, input string nm);
      pc = 8'(a);
      #1;
      check(nm, 32'(instruction), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      // Reset values
      check("rst_stall", 32'(cpu_stall), 32'd1);
      check("rst_ready", 32'(load_ready), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_checksum", 32'(checksum), 32'd0);
      check("rst_instr", 32'(instruction), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Illegal lengths in BOOT
      exp_err++;
      issue_start(0);
      wait_drain();
      check("bad0_stall", 32'(cpu_stall), 32'd1);
      check("bad0_ready", 32'(load_ready), 32'd0);
      exp_err++;
      issue_start(257);
      wait_drain();
      check("bad257_stall", 32'(cpu_stall), 32'd1);
      check("bad257_busy", 32'(busy), 32'd0);

      // Boot load of 9 words
      for (int i = 0; i < 9; i++) wbuf[i] = 16'h9208 + 16'(i) * 16'h0240;
      expect_load(9, 9);
      issue_start(9);
      check("boot_busy", 32'(busy), 32'd1);
      stream(9, 0, 16'h0, -1);
      wait_drain();
      check("boot_done_latency", 32'(last_done_cyc - start_cyc), 32'd10);
      fetch(0, 16'h9208, "boot_pc0");
      fetch(8, 16'hA408, "boot_pc8");

      // Backpressure: valid 1,0,0,1,1,0,1
      wbuf[0] = 16'h0F01; wbuf[1] = 16'h00F2; wbuf[2] = 16'h3004; wbuf[3] = 16'h4008;
      expect_load(4, 4);
      issue_start(4);
      stream(4, 7, 16'h0059, -1);
      wait_drain();
      check("bp_checksum", 32'(checksum), 32'h7FFF);
      fetch(3, 16'h4008, "bp_pc3");
      fetch(4, 16'h9B08, "bp_pc4_untouched");

      // Reload from RUN with an ignored second start
      wbuf[0] = 16'hA001; wbuf[1] = 16'hA002;
      expect_load(2, 2);
      pc = 8'd3;
      issue_start(2);
      stream(2, 0, 16'h0, 1);
      wait_drain();
      fetch(0, 16'hA001, "reload_pc0");
      fetch(1, 16'hA002, "reload_pc1");
      fetch(2, 16'h3004, "reload_pc2_kept");

      // Full-depth load
      for (int i = 0; i < 256; i++) wbuf[i] = 16'hC300 ^ 16'(i);
      expect_load(256, 256);
      issue_start(256);
      stream(256, 0, 16'h0, -1);
      wait_drain();
      check("full_done_latency", 32'(last_done_cyc - start_cyc), 32'd257);
      fetch(255, 16'hC3FF, "full_pc255");
      fetch(0, 16'hC300, "full_pc0");

      // Reset after 3 of 8 words
      for (int i = 0; i < 8; i++) wbuf[i] = 16'h5A00 + 16'(i);
      expect_load(8, 3);
      issue_start(8);
      stream(3, 0, 16'h0, -1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_stall", 32'(cpu_stall), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ready", 32'(load_ready), 32'd0);
      check("mid_rst_ram0", 32'(u_ram.mem[0]), 32'h5A00);
      check("mid_rst_ram2", 32'(u_ram.mem[2]), 32'h5A02);
      check("mid_rst_ram3", 32'(u_ram.mem[3]), 32'hC303);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_stall", 32'(cpu_stall), 32'd1);
      check("post_rst_instr", 32'(instruction), 32'd0);
      wait_drain();
      for (int i = 0; i < 8; i++) wbuf[i] = 16'h6B00 + 16'(i);
      expect_load(8, 8);
      issue_start(8);
      stream(8, 0, 16'h0, -1);
      wait_drain();
      check("reboot_done_latency", 32'(last_done_cyc - start_cyc), 32'd9);
      fetch(7, 16'h6B07, "reboot_pc7");
      fetch(8, 16'hC308, "reboot_pc8_kept");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
